// File: rtl/fetch_stage_if.sv
// Instruction-memory bus between the fetch stage and the memory.
// Combinational-stall memory: imem_ready qualifies the address presented in the same cycle.
interface fetch_stage_if;
    logic [15:0] imem_addr;
    logic        imem_rd;
    logic        imem_ready;
    logic [15:0] imem_data;

    modport master (
        output imem_addr, imem_rd,
        input  imem_ready, imem_data
    );

    modport slave (
        input  imem_addr, imem_rd,
        output imem_ready, imem_data
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch and IF/ID register for the 16-bit five-stage core.
// Owns the PC, issues imem reads and handles redirect, stalls and HALT.
module fetch_stage #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0800,
    parameter logic [4:0]  HALT_OPC  = 5'b00000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          branchStall,
    input  logic          dataHazardStall,
    input  logic          pcRedirect,
    input  logic [15:0]   redirectPC,
    fetch_stage_if.master imem,
    output logic [15:0]   instr_IFID,
    output logic [15:0]   pcPlus2_IFID,
    output logic          valid_IFID,
    output logic          halted,
    output logic          err
);

    typedef enum logic [1:0] {
        RUN,
        WAIT,
        HALT
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] pc2_q, pc2_d;
    logic        valid_q, valid_d;
    logic        halted_q, halted_d;
    logic        err_q, err_d;

    logic in_halt;
    logic fetch;
    logic quiet;
    logic redir, hold, idle, bstall, mwait, accept;

    assign in_halt = (state_q == HALT);
    assign fetch   = !in_halt && !branchStall;
    assign quiet   = !pcRedirect && !dataHazardStall;

    // Mutually exclusive edge actions, in priority order
    assign redir  = pcRedirect && !in_halt;
    assign hold   = !redir && dataHazardStall;
    assign idle   = in_halt && !dataHazardStall;
    assign bstall = !in_halt && quiet && branchStall;
    assign mwait  = fetch && quiet && !imem.imem_ready;
    assign accept = fetch && quiet && imem.imem_ready;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        pc2_d    = pc2_q;
        valid_d  = valid_q;
        halted_d = halted_q;
        err_d    = err_q;
        unique case (1'b1)
            redir: begin
                instr_d = NOP_INSTR;
                valid_d = 1'b0;
                if (redirectPC[0]) begin
                    err_d   = 1'b1;
                    state_d = HALT;
                end else begin
                    pc_d    = redirectPC;
                    state_d = RUN;
                end
            end
            hold: begin
            end
            idle: begin
                instr_d = NOP_INSTR;
                valid_d = 1'b0;
            end
            bstall: begin
                instr_d = NOP_INSTR;
                valid_d = 1'b0;
                state_d = RUN;
            end
            mwait: begin
                instr_d = NOP_INSTR;
                valid_d = 1'b0;
                state_d = WAIT;
            end
            accept: begin
                instr_d = imem.imem_data;
                pc2_d   = pc_q + 16'd2;
                valid_d = 1'b1;
                if (imem.imem_data[15:11] == HALT_OPC) begin
                    state_d  = HALT;
                    halted_d = 1'b1;
                end else begin
                    pc_d    = pc_q + 16'd2;
                    state_d = RUN;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RUN;
            pc_q     <= RESET_PC;
            instr_q  <= NOP_INSTR;
            pc2_q    <= 16'h0000;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            pc2_q    <= pc2_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
            err_q    <= err_d;
        end
    end

    assign imem.imem_addr = pc_q;
    assign imem.imem_rd   = fetch;
    assign instr_IFID     = instr_q;
    assign pcPlus2_IFID   = pc2_q;
    assign valid_IFID     = valid_q;
    assign halted         = halted_q;
    assign err            = err_q;

endmodule
